// File: rtl/console_input_arbiter_pkg.sv
// Shared definitions for the console input arbiter.
//   CHAR_CR      : carriage return, terminates a locked line
//   SRC_UART/PS2 : source encoding used on IN_SOURCE and for round-robin
//   arb_state_t  : line-lock scheduler states
package console_pkg;

   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic       SRC_UART = 1'b0;
   localparam logic       SRC_PS2  = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      LOCK_UART,
      LOCK_PS2
   } arb_state_t;

endpackage

// File: rtl/console_input_arbiter_byte_fifo.sv
// Synchronous byte FIFO, one per console source.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/data_i : write a byte (ignored when full unless popped same cycle)
//   pop_i         : remove the head byte (ignored when empty)
//   empty_o/full_o: occupancy flags
//   head_o        : current head byte (valid when not empty)
module byte_fifo
   import console_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic       empty_o,
   output logic       full_o,
   output logic [7:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [DEPTH];
   logic        push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the head slot in the same cycle, so a push into a full
   // FIFO is accepted when it coincides with a pop.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/console_input_arbiter.sv
// Console input arbiter: merges UART and PS/2 byte streams into the CPU's
// single input port, keeping each line (up to CR) from one source together.
// Ports:
//   CLK_25MHZ, RESET_N        : clock, asynchronous active-low reset
//   UART_VALID/UART_DATA      : UART byte strobe (no backpressure)
//   PS2_VALID/PS2_DATA        : keyboard ASCII byte strobe (no backpressure)
//   IN_VALID/IN_DATA/IN_SOURCE: registered output slot to the CPU
//   IN_READY                  : CPU accepts when IN_VALID && IN_READY at a rising edge
//   UART_OVF/PS2_OVF          : sticky drop flags, cleared by OVF_CLR
//   DBG_STATE                 : current scheduler state
// Handshake: a byte transfers on a rising edge where IN_VALID and IN_READY
// are both high; while IN_VALID=1 and IN_READY=0 the slot holds its contents.
module console_input_arbiter
   import console_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int LOCK_TIMEOUT = 25000000
) (
   input  logic       CLK_25MHZ,
   input  logic       RESET_N,
   input  logic       UART_VALID,
   input  logic [7:0] UART_DATA,
   input  logic       PS2_VALID,
   input  logic [7:0] PS2_DATA,
   output logic       IN_VALID,
   output logic [7:0] IN_DATA,
   output logic       IN_SOURCE,
   input  logic       IN_READY,
   output logic       UART_OVF,
   output logic       PS2_OVF,
   input  logic       OVF_CLR,
   output arb_state_t DBG_STATE
);

   localparam int            TW         = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

   logic       u_empty, u_full, u_push, u_pop;
   logic       p_empty, p_full, p_push, p_pop;
   logic [7:0] u_head, p_head;

   arb_state_t    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          in_valid_q, in_valid_d;
   logic [7:0]    in_data_q, in_data_d;
   logic          in_src_q, in_src_d;
   logic          uart_ovf_q, uart_ovf_d;
   logic          ps2_ovf_q, ps2_ovf_d;

   logic       slot_free, elig_u, elig_p, grant, grant_src, lock_empty;
   logic [7:0] grant_byte;

   byte_fifo #(.DEPTH(DEPTH)) u_uart_fifo (
      .clk_i  (CLK_25MHZ),
      .rst_ni (RESET_N),
      .push_i (u_push),
      .data_i (UART_DATA),
      .pop_i  (u_pop),
      .empty_o(u_empty),
      .full_o (u_full),
      .head_o (u_head)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_ps2_fifo (
      .clk_i  (CLK_25MHZ),
      .rst_ni (RESET_N),
      .push_i (p_push),
      .data_i (PS2_DATA),
      .pop_i  (p_pop),
      .empty_o(p_empty),
      .full_o (p_full),
      .head_o (p_head)
   );

   // Grant selection: the slot refills in the same cycle it is consumed.
   always_comb begin
      slot_free  = !in_valid_q || IN_READY;
      elig_u     = 1'b0;
      elig_p     = 1'b0;
      lock_empty = 1'b0;
      case (state_q)
         IDLE: begin
            elig_u = !u_empty;
            elig_p = !p_empty;
         end
         LOCK_UART: begin
            elig_u     = !u_empty;
            lock_empty = u_empty;
         end
         LOCK_PS2: begin
            elig_p     = !p_empty;
            lock_empty = p_empty;
         end
         default: ;
      endcase
      grant = slot_free && (elig_u || elig_p);
      if (elig_u && elig_p) grant_src = ~last_grant_q;
      else                  grant_src = elig_p ? SRC_PS2 : SRC_UART;
      grant_byte = (grant_src == SRC_PS2) ? p_head : u_head;
   end

   assign u_pop  = grant && (grant_src == SRC_UART);
   assign p_pop  = grant && (grant_src == SRC_PS2);
   assign u_push = UART_VALID && (!u_full || u_pop);
   assign p_push = PS2_VALID && (!p_full || p_pop);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      in_valid_d   = in_valid_q && !IN_READY;
      in_data_d    = in_data_q;
      in_src_d     = in_src_q;

      if (grant) begin
         in_valid_d   = 1'b1;
         in_data_d    = grant_byte;
         in_src_d     = grant_src;
         last_grant_d = grant_src;
      end

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (grant && (grant_byte != CHAR_CR))
               state_d = (grant_src == SRC_PS2) ? LOCK_PS2 : LOCK_UART;
         end
         LOCK_UART, LOCK_PS2: begin
            // A grant outranks a timeout expiring in the same cycle.
            if (grant) begin
               timer_d = '0;
               if (grant_byte == CHAR_CR) state_d = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (lock_empty && (timer_q != '1)) begin
               timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh drop beats a simultaneous clear.
      uart_ovf_d = (UART_VALID && !u_push) ? 1'b1 : (OVF_CLR ? 1'b0 : uart_ovf_q);
      ps2_ovf_d  = (PS2_VALID && !p_push)  ? 1'b1 : (OVF_CLR ? 1'b0 : ps2_ovf_q);
   end

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= IDLE;
         last_grant_q <= SRC_PS2;
         timer_q      <= '0;
         in_valid_q   <= 1'b0;
         in_data_q    <= 8'h00;
         in_src_q     <= SRC_UART;
         uart_ovf_q   <= 1'b0;
         ps2_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         in_valid_q   <= in_valid_d;
         in_data_q    <= in_data_d;
         in_src_q     <= in_src_d;
         uart_ovf_q   <= uart_ovf_d;
         ps2_ovf_q    <= ps2_ovf_d;
      end
   end

   assign IN_VALID  = in_valid_q;
   assign IN_DATA   = in_data_q;
   assign IN_SOURCE = in_src_q;
   assign UART_OVF  = uart_ovf_q;
   assign PS2_OVF   = ps2_ovf_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_console_input_arbiter.sv
module tb_console_input_arbiter;
   import console_pkg::*;

   localparam int DEPTH = 4;
   localparam int LT    = 16;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       uart_valid = 1'b0, ps2_valid = 1'b0, in_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] uart_data = 8'h00, ps2_data = 8'h00;
   logic       in_valid, in_source, uart_ovf, ps2_ovf;
   logic [7:0] in_data;
   arb_state_t dbg_state;

   console_input_arbiter #(.DEPTH(DEPTH), .LOCK_TIMEOUT(LT)) dut (
      .CLK_25MHZ (clk),
      .RESET_N   (rst_n),
      .UART_VALID(uart_valid),
      .UART_DATA (uart_data),
      .PS2_VALID (ps2_valid),
      .PS2_DATA  (ps2_data),
      .IN_VALID  (in_valid),
      .IN_DATA   (in_data),
      .IN_SOURCE (in_source),
      .IN_READY  (in_ready),
      .UART_OVF  (uart_ovf),
      .PS2_OVF   (ps2_ovf),
      .OVF_CLR   (ovf_clr),
      .DBG_STATE (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   logic [8:0] exp_q[$];   // {source, data}
   logic [8:0] exp_e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic uart_send(input logic [7:0] b);
      uart_valid = 1'b1;
      uart_data  = b;
      tick();
      uart_valid = 1'b0;
   endtask

   task automatic ps2_send(input logic [7:0] b);
      ps2_valid = 1'b1;
      ps2_data  = b;
      tick();
      ps2_valid = 1'b0;
   endtask

   task automatic both_send(input logic [7:0] u, input logic [7:0] p);
      uart_valid = 1'b1;
      uart_data  = u;
      ps2_valid  = 1'b1;
      ps2_data   = p;
      tick();
      uart_valid = 1'b0;
      ps2_valid  = 1'b0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      uart_valid = 1'b0;
      ps2_valid  = 1'b0;
      in_ready   = 1'b0;
      ovf_clr    = 1'b0;
      #2;
      chk("rst_valid", in_valid, 0);
      chk("rst_data", in_data, 0);
      chk("rst_src", in_source, 0);
      chk("rst_uovf", uart_ovf, 0);
      chk("rst_povf", ps2_ovf, 0);
      chk("rst_state", dbg_state, IDLE);
      tick();
      tick();
      exp_q.delete();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk("drain_left", exp_q.size(), 0);
   endtask

   // scoreboard: compare every accepted byte against the expected queue
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {23'd0, in_source, in_data}, 32'h1ff);
         end else begin
            exp_e = exp_q.pop_front();
            chk("out", {23'd0, in_source, in_data}, {23'd0, exp_e});
         end
      end
   end

   int         cyc;
   logic       seen;
   logic [7:0] rb;

   initial begin
      // single byte latency
      do_reset();
      in_ready = 1'b1;
      exp_q.push_back({SRC_UART, 8'h41});
      uart_send(8'h41);
      tick();
      chk("single_valid", in_valid, 1);
      chk("single_data", in_data, 8'h41);
      chk("single_src", in_source, 0);
      chk("single_state", dbg_state, LOCK_UART);
      drain();

      // line lock with interleaved strobes
      do_reset();
      in_ready = 1'b1;
      exp_q.push_back({SRC_UART, 8'h41});
      exp_q.push_back({SRC_UART, 8'h42});
      exp_q.push_back({SRC_UART, 8'h0D});
      exp_q.push_back({SRC_PS2, 8'h78});
      exp_q.push_back({SRC_PS2, 8'h79});
      uart_send(8'h41);
      ps2_send(8'h78);
      uart_send(8'h42);
      ps2_send(8'h79);
      uart_send(8'h0D);
      drain();

      // tie from reset: UART first, both CR so stay IDLE
      do_reset();
      in_ready = 1'b1;
      exp_q.push_back({SRC_UART, 8'h0D});
      exp_q.push_back({SRC_PS2, 8'h0D});
      both_send(8'h0D, 8'h0D);
      drain();
      chk("tie_state", dbg_state, IDLE);

      // backpressure and overflow
      do_reset();
      in_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) exp_q.push_back({SRC_PS2, 8'h31 + 8'(i)});
         ps2_send(8'h31 + 8'(i));
      end
      chk("bp_valid", in_valid, 1);
      chk("bp_data", in_data, 8'h31);
      chk("bp_src", in_source, 1);
      chk("bp_povf", ps2_ovf, 1);
      chk("bp_uovf", uart_ovf, 0);
      ovf_clr = 1'b1;
      ps2_send(8'h37);
      ovf_clr = 1'b0;
      chk("clr_vs_drop", ps2_ovf, 1);
      chk("bp_hold", in_data, 8'h31);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("clr_alone", ps2_ovf, 0);
      // push into the full FIFO on the cycle its head is popped
      in_ready = 1'b1;
      exp_q.push_back({SRC_PS2, 8'h38});
      ps2_send(8'h38);
      chk("full_pop_push_ovf", ps2_ovf, 0);
      drain();

      // lock timeout
      do_reset();
      in_ready = 1'b1;
      exp_q.push_back({SRC_UART, 8'h41});
      exp_q.push_back({SRC_PS2, 8'h62});
      uart_send(8'h41);
      ps2_send(8'h62);
      cyc  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         cyc++;
         if (cyc == LT - 1) chk("to_state_locked", dbg_state, LOCK_UART);
         if (cyc == LT)     chk("to_state_idle", dbg_state, IDLE);
         if (in_valid && in_source) seen = 1'b1;
      end
      chk("to_seen", seen, 1);
      chk("to_cycles", cyc, LT + 1);
      drain();

      // asynchronous reset while a byte is presented
      do_reset();
      in_ready = 1'b0;
      uart_send(8'h41);
      uart_send(8'h42);
      chk("ar_valid_before", in_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", in_valid, 0);
      chk("ar_data", in_data, 0);
      chk("ar_state", dbg_state, IDLE);
      exp_q.delete();
      tick();
      rst_n    = 1'b1;
      in_ready = 1'b1;
      seen     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (in_valid) seen = 1'b1;
      end
      chk("ar_fifo_empty", seen, 0);
      chk("ar_state_after", dbg_state, IDLE);

      // random lines, one source at a time, random backpressure
      do_reset();
      for (int l = 0; l < 4; l++) begin
         for (int k = 0; k < 5; k++) begin
            rb = (k == 4) ? CHAR_CR : 8'($urandom_range(32, 126));
            exp_q.push_back({l[0], rb});
            in_ready = (k % 4 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (l[0]) ps2_send(rb);
            else      uart_send(rb);
            tick();
            tick();
         end
         in_ready = 1'b1;
         drain();
         chk("rnd_state", dbg_state, IDLE);
      end
      chk("rnd_uovf", uart_ovf, 0);
      chk("rnd_povf", ps2_ovf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/console_input_arbiter.md
Name: console_input_arbiter

Overview:
Shares the TinyBASIC CPU's single console-input port between two byte sources: the UART receiver and the PS/2 scancode-to-ASCII decoder. Each source has a small FIFO. A line-lock scheduler keeps a source's bytes together until carriage return, so lines from the two sources never interleave. Sits in topEntity between the RX/PS2 front-ends and the CPU input handshake, all in the 25 MHz domain.

Parameters:
DEPTH, 4, per-source FIFO depth in bytes; power of 2, at least 2
LOCK_TIMEOUT, 25000000, idle cycles (1 s at 25 MHz) after which a held line lock is released

Ports:
CLK_25MHZ  in  1  system clock, 25 MHz
RESET_N  in  1  asynchronous, active-low reset
UART_VALID  in  1  single-cycle strobe: UART_DATA is a new byte; no backpressure
UART_DATA  in  8  UART received byte
PS2_VALID  in  1  single-cycle strobe: PS2_DATA is a new ASCII byte; no backpressure
PS2_DATA  in  8  decoded keyboard ASCII byte
IN_VALID  out  1  output byte available to CPU
IN_DATA  out  8  output byte
IN_SOURCE  out  1  source of IN_DATA: 0 = UART, 1 = PS2
IN_READY  in  1  CPU accepts byte when IN_VALID and IN_READY are both high at a rising edge
UART_OVF  out  1  sticky: a UART byte was dropped
PS2_OVF  out  1  sticky: a PS2 byte was dropped
OVF_CLR  in  1  clears both overflow flags

Behaviour:
- Interface: one clock, CLK_25MHZ; reset RESET_N is asynchronous, active-low. On assertion, immediately: both FIFOs empty; IN_VALID=0, IN_DATA=0x00, IN_SOURCE=0; UART_OVF=0, PS2_OVF=0; state=IDLE; lock timer=0; last_grant=PS2.
- Push:
  - A strobe writes its byte into its own FIFO.
  - If that FIFO is full and is not being popped in the same cycle, the byte is dropped and the source's OVF flag is set.
  - A push into a full FIFO that is popped in the same cycle is accepted.
- Output slot:
  - A single register stage feeds IN_VALID, IN_DATA and IN_SOURCE.
  - The slot is free when IN_VALID=0, or when IN_VALID and IN_READY are both high (the pop is combined with the handshake, giving full throughput of 1 byte/cycle).
  - IN_DATA and IN_SOURCE hold stable while IN_VALID=1 and IN_READY=0.
- Latency: a strobe at edge N with empty FIFOs and a free slot gives IN_VALID=1 after edge N+1.
- State machine (states IDLE, LOCK_UART, LOCK_PS2). A grant pops the chosen FIFO head into the slot; grants happen only when the slot is free.
  - IDLE: eligible sources are those with a non-empty FIFO. If both are eligible, round-robin: grant the source that is not last_grant. Update last_grant. If the granted byte is not 0x0D, go to LOCK_<src>; otherwise stay in IDLE.
  - LOCK_X: only X is eligible; the other FIFO keeps accepting pushes and may overflow.
    - Granting 0x0D from X returns to IDLE.
    - The timer increments each cycle that X's FIFO is empty and resets to 0 on any grant.
    - When the timer reaches LOCK_TIMEOUT-1, go to IDLE and clear the timer. A grant has priority over the timeout in the same cycle.
- Timer width is clog2(LOCK_TIMEOUT); the timer saturates and never wraps.
- OVF flags: OVF_CLR clears both. A new drop in the same cycle as OVF_CLR wins, so the flag is set.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is when the MSBs differ and the low bits are equal.
- Reset mid-transfer discards all bytes, including one presented on IN_VALID.

Decomposition:
- Package console_pkg holds:
  - CHAR_CR = 8'h0D
  - SRC_UART = 1'b0, SRC_PS2 = 1'b1
  - the state enum arb_state_t {IDLE, LOCK_UART, LOCK_PS2}
- One sub-module, byte_fifo: a synchronous FIFO parameterised by DEPTH, with push/pop/empty/full/head ports and the same clock and reset. It is instantiated twice.
- The arbiter, FSM, timer and flags live in console_input_arbiter.

Test Plan:
- Single byte: UART strobe 0x41 at edge 0, IN_READY=1 -> IN_VALID=1, IN_DATA=0x41, IN_SOURCE=0 after edge 1; state=LOCK_UART.
- Line lock:
  - Stimulus: UART "AB\r" and PS2 "xy" interleaved, IN_READY=1, LOCK_TIMEOUT=16.
  - Required: output A,B,0x0D (src 0), then x,y (src 1), no interleaving.
- Tie: both strobe 0x0D in the same cycle from reset -> UART 0x0D granted first, then PS2 0x0D; state stays IDLE.
- Backpressure and overflow:
  - Stimulus: IN_READY=0, DEPTH=4, six PS2 bytes 0x31..0x36.
  - Required: IN_DATA holds 0x31; FIFO holds 0x32..0x35; 0x36 dropped; PS2_OVF=1.
  - Then pulse OVF_CLR together with a dropped byte -> PS2_OVF stays 1.
- Timeout: UART sends 0x41 only (lock), then PS2 sends 0x62 -> 0x62 is held for exactly LOCK_TIMEOUT idle cycles, then granted with IN_SOURCE=1.
- Async reset: drop RESET_N mid-line while IN_VALID=1 -> IN_VALID=0 with no clock edge; after release, state=IDLE and the FIFOs are empty.
